// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, prescale/counter widths and
// the oversample factor, used by both the receive and transmit sides.
package uart_pkg;

    localparam int PRESCALE_W = 16;
    localparam int OVERSAMPLE = 8;
    localparam int CNT_W      = PRESCALE_W + 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // A prescale of zero would stall the bit counter, so it runs as one.
    function automatic logic [PRESCALE_W-1:0] eff_prescale(input logic [PRESCALE_W-1:0] p);
        return (p == '0) ? PRESCALE_W'(1) : p;
    endfunction

    function automatic logic [CNT_W-1:0] bit_ticks(input logic [PRESCALE_W-1:0] p);
        return CNT_W'(p) * CNT_W'(OVERSAMPLE);
    endfunction

    function automatic logic [CNT_W-1:0] half_ticks(input logic [PRESCALE_W-1:0] p);
        return CNT_W'(p) * CNT_W'(OVERSAMPLE / 2);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a
// selectable reset value so idle-high and idle-low lines both work.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: oversampled start/data/stop recovery with an
// AXI-stream output register and one-cycle frame/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rxd_s;
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [PRESCALE_W-1:0] p_lat;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  expire;
    logic                  byte_done;
    logic                  frame_bad;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    // Sample points are the cycles where the counter steps from 1 to 0.
    assign expire    = (cnt == CNT_W'(1));
    assign byte_done = (state == ST_STOP) && expire && rxd_s;
    assign frame_bad = (state == ST_STOP) && expire && !rxd_s;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            p_lat   <= PRESCALE_W'(1);
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        p_lat <= eff_prescale(prescale);
                        cnt   <= half_ticks(eff_prescale(prescale));
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (expire) begin
                        if (!rxd_s) begin
                            cnt     <= bit_ticks(p_lat);
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end else begin
                            // Start bit gone high at mid-bit: a glitch, drop it quietly.
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (expire) begin
                        shreg <= {rxd_s, shreg[DATA_WIDTH-1:1]};
                        cnt   <= bit_ticks(p_lat);
                        if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    if (expire) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // A new byte always wins over a pending one; overrun flags the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun_error <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            frame_error   <= frame_bad;
            if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (byte_done) begin
                m_axis_tdata  <= shreg;
                m_axis_tvalid <= 1'b1;
                overrun_error <= m_axis_tvalid && !m_axis_tready;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table-driven frames, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready = 1'b1;
    logic          rxd = 1'b1;
    logic          busy;
    logic          ov;
    logic          fe;
    logic [15:0]   prescale = 16'd1;

    always #5 clk = ~clk;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .rxd           (rxd),
        .busy          (busy),
        .overrun_error (ov),
        .frame_error   (fe),
        .prescale      (prescale)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: only accumulates; the test process reads deltas.
    logic [DW-1:0] got_q[$];
    int  fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0;
    int  tv_high = 0, busy_cnt = 0, rise_cyc = 0;
    bit  prev_tv = 0, prev_fe = 0, prev_ov = 0;

    always @(negedge clk) begin
        if (tvalid && !prev_tv) rise_cyc = cyc;
        if (tvalid) tv_high++;
        if (tvalid && tready) got_q.push_back(tdata);
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (fe && prev_fe) fe_wide++;
        if (ov && prev_ov) ov_wide++;
        if (busy) busy_cnt++;
        prev_tv = tvalid;
        prev_fe = fe;
        prev_ov = ov;
    end

    int n_tests = 0, n_fail = 0;
    int start_cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs change 2ns after a rising edge; outputs are read at the falling edge.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input int pb, input logic stop,
                              input int chg_bit, input logic [15:0] chg_ps);
        start_cyc = cyc;
        rxd = 1'b0;
        wait_cyc(8 * pb);
        for (int k = 0; k < DW; k++) begin
            if (k == chg_bit) prescale = chg_ps;
            rxd = d[k];
            wait_cyc(8 * pb);
        end
        rxd = stop;
        wait_cyc(8 * pb);
        rxd = 1'b1;
    endtask

    // Pin falls at cycle c0; 2 sync flops + 1 detect edge, then half bit,
    // DW data bits and the stop bit, each 8P; tvalid is seen the cycle after.
    function automatic int exp_latency(input int p);
        return 3 + 4 * p + 8 * p * (DW + 1);
    endfunction

    task automatic frame_check(input string nm, input logic [15:0] ps, input logic [DW-1:0] d,
                               input logic stop, input bit exp_valid, input bit exp_fe);
        int g0, f0, o0, t0, eff;
        eff = (ps == 16'd0) ? 1 : int'(ps);
        tready = 1'b1;
        prescale = ps;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; t0 = tv_high;
        send_frame(d, eff, stop, -1, 16'd0);
        wait_cyc(8 * eff + 40);
        chk({nm, " bytes"}, got_q.size() - g0, exp_valid ? 1 : 0);
        if (exp_valid && got_q.size() > g0) begin
            chk({nm, " data"}, int'(got_q[got_q.size() - 1]), int'(d));
            chk({nm, " latency"}, rise_cyc - start_cyc, exp_latency(eff));
        end
        chk({nm, " tvalid cycles"}, tv_high - t0, exp_valid ? 1 : 0);
        chk({nm, " frame_error"}, fe_cnt - f0, exp_fe ? 1 : 0);
        chk({nm, " overrun"}, ov_cnt - o0, 0);
        chk({nm, " idle busy"}, int'(busy), 0);
    endtask

    typedef struct {
        logic [15:0]   ps;
        logic [DW-1:0] data;
        logic          stop;
        bit            exp_valid;
        bit            exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int g0, f0, o0, t0, b0;
        logic [DW-1:0] rd;
        logic [15:0]   rp;
        logic          rs;
        int            reff;

        vecs[0] = '{16'd1, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'd3, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'd2, 8'hFF, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{16'd2, 8'h12, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'd0, 8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'd1, 8'h80, 1'b1, 1'b1, 1'b0};

        // Reset state
        wait_cyc(3);
        chk("reset tvalid", int'(tvalid), 0);
        chk("reset tdata", int'(tdata), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset errors", int'({fe, ov}), 0);
        rst_n = 1'b1;
        wait_cyc(4);

        foreach (vecs[i]) begin
            frame_check($sformatf("vec%0d", i), vecs[i].ps, vecs[i].data, vecs[i].stop,
                        vecs[i].exp_valid, vecs[i].exp_fe);
        end

        // Overrun: first byte left unaccepted, second overwrites it.
        tready = 1'b0;
        prescale = 16'd4;
        g0 = got_q.size(); o0 = ov_cnt;
        send_frame(8'hA3, 4, 1'b1, -1, 16'd0);
        wait_cyc(72);
        send_frame(8'h0F, 4, 1'b1, -1, 16'd0);
        wait_cyc(72);
        chk("overrun pulses", ov_cnt - o0, 1);
        chk("overrun tdata", int'(tdata), 8'h0F);
        chk("overrun tvalid held", int'(tvalid), 1);
        tready = 1'b1;
        wait_cyc(1);
        tready = 1'b0;
        wait_cyc(1);
        chk("overrun accepted count", got_q.size() - g0, 1);
        if (got_q.size() > g0) chk("overrun accepted data", int'(got_q[got_q.size() - 1]), 8'h0F);
        chk("tvalid drops after accept", int'(tvalid), 0);
        tready = 1'b1;
        wait_cyc(4);

        // Short low glitch: busy pulses, nothing else.
        prescale = 16'd2;
        g0 = got_q.size(); f0 = fe_cnt; o0 = ov_cnt; t0 = tv_high; b0 = busy_cnt;
        rxd = 1'b0;
        wait_cyc(3);
        rxd = 1'b1;
        wait_cyc(40);
        chk("glitch busy seen", int'(busy_cnt - b0 > 0), 1);
        chk("glitch busy cleared", int'(busy), 0);
        chk("glitch no tvalid", tv_high - t0, 0);
        chk("glitch no bytes", got_q.size() - g0, 0);
        chk("glitch no errors", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Reset mid-DATA with a byte pending in the output register.
        tready = 1'b0;
        prescale = 16'd1;
        send_frame(8'h77, 1, 1'b1, -1, 16'd0);
        wait_cyc(20);
        chk("pre-reset tvalid", int'(tvalid), 1);
        rxd = 1'b0;                     // start of 0xC3
        wait_cyc(8);
        for (int k = 0; k < 3; k++) begin
            rxd = k[0] ? 1'b1 : 1'b1;   // C3 bits 0,1 are 1; bit 2 is 0
            if (k == 2) rxd = 1'b0;
            wait_cyc(8);
        end
        chk("pre-reset busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid reset tvalid", int'(tvalid), 0);
        chk("mid reset tdata", int'(tdata), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset errors", int'({fe, ov}), 0);
        @(posedge clk); #2;
        rxd = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        tready = 1'b1;
        wait_cyc(4);
        g0 = got_q.size();
        frame_check("after reset", 16'd1, 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("after reset only one byte", got_q.size() - g0, 1);

        // Prescale change mid-frame applies to the next frame only.
        prescale = 16'd1;
        g0 = got_q.size();
        send_frame(8'h81, 1, 1'b1, 3, 16'd2);
        wait_cyc(40);
        chk("ps change bytes", got_q.size() - g0, 1);
        if (got_q.size() > g0) chk("ps change data", int'(got_q[got_q.size() - 1]), 8'h81);
        chk("ps change latency", rise_cyc - start_cyc, exp_latency(1));
        frame_check("ps change next", 16'd2, 8'h5A, 1'b1, 1'b1, 1'b0);

        // Randomized frames against the frame-level model.
        for (int n = 0; n < 16; n++) begin
            rd = DW'($urandom);
            rp = 16'($urandom_range(0, 3));
            rs = ($urandom_range(0, 4) != 0);
            reff = (rp == 16'd0) ? 1 : int'(rp);
            if (reff < 1) reff = 1;
            frame_check($sformatf("rand%0d", n), rp, rd, rs, rs, !rs);
        end

        chk("frame_error width", fe_wide, 0);
        chk("overrun width", ov_wide, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
